// File: rtl/l2_snoop_responder.sv
// l2_snoop_responder
// Snoop-side responder for the L2 cache. Watches bus operations issued by other
// caches, looks the line up in the L2 tag/MESI array, answers NOHIT/HIT/HITM on
// snoopBus, requests a writeback of modified lines and updates the MESI state.
// Optional feature macro: SNOOP_PROTOCOL_CHECK_EN enables protocolError pulses
// (and a simulation $error per violation). Without it protocolError is tied 0.
module l2_snoop_responder #(
    parameter int unsigned addressSize = 32,
    parameter int unsigned ways        = 8,
    parameter int unsigned indexBits   = 14,
    parameter int unsigned byteSelect  = 9,
    parameter int unsigned tagBits     = addressSize - indexBits - byteSelect
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       opValid,
    input  logic                       ownRequest,
    input  logic [7:0]                 sharedOperationBus,
    input  logic [addressSize-1:0]     snoopAddress,
    output logic                       lookupReq,
    output logic [indexBits-1:0]       lookupIndex,
    output logic [tagBits-1:0]         lookupTag,
    input  logic                       lookupAck,
    input  logic                       lookupHit,
    input  logic [$clog2(ways)-1:0]    lookupWay,
    input  logic [1:0]                 lookupState,
    output logic [1:0]                 snoopBus,
    output logic                       snoopValid,
    output logic                       wbReq,
    output logic [indexBits-1:0]       wbIndex,
    output logic [$clog2(ways)-1:0]    wbWay,
    input  logic                       wbAck,
    output logic                       stateWrite,
    output logic [indexBits-1:0]       stateIndex,
    output logic [$clog2(ways)-1:0]    stateWay,
    output logic [1:0]                 stateNew,
    output logic                       busy,
    output logic                       protocolError
);

    localparam int unsigned WAY_W = $clog2(ways);

    // FSM encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_RESPOND   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_UPDATE    = 3'd4;

    // Bus opcodes (ASCII)
    localparam logic [7:0] OP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OP_RWIM  = 8'h4D;  // 'M'
    localparam logic [7:0] OP_INV   = 8'h49;  // 'I'

    // MESI encoding
    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    // Snoop responses
    localparam logic [1:0] RESP_NOHIT = 2'b00;
    localparam logic [1:0] RESP_HIT   = 2'b01;
    localparam logic [1:0] RESP_HITM  = 2'b10;

    // State and captured operation
    logic [2:0]           r_state,         w_state_nxt;
    logic [7:0]           r_opcode,        w_opcode_nxt;
    logic [indexBits-1:0] r_index,         w_index_nxt;
    logic [tagBits-1:0]   r_tag,           w_tag_nxt;
    logic [WAY_W-1:0]     r_way,           w_way_nxt;
    logic [1:0]           r_resp,          w_resp_nxt;
    logic                 r_update,        w_update_nxt;
    logic [1:0]           r_stateNew,      w_stateNew_nxt;

    // Registered strobes and flags
    logic                 r_lookupReq,     w_lookupReq_nxt;
    logic                 r_snoopValid,    w_snoopValid_nxt;
    logic [1:0]           r_snoopBus,      w_snoopBus_nxt;
    logic                 r_wbReq,         w_wbReq_nxt;
    logic                 r_stateWrite,    w_stateWrite_nxt;
    logic                 r_busy,          w_busy_nxt;
    logic                 r_protocolError, w_protocolError_nxt;

    // Lookup result decode
    logic                 w_opRecognized;
    logic                 w_validHit;
    logic [1:0]           w_lkResp;
    logic                 w_lkUpdate;
    logic [1:0]           w_lkStateNew;
    logic                 w_lkViolate;
    logic                 w_errBusy;
    logic                 w_errLookup;

    // Byte-offset bits never take part in a snoop lookup
    logic [byteSelect-1:0] w_unused_offset;
    assign w_unused_offset = snoopAddress[byteSelect-1:0];

    // Only the four bus opcodes start a snoop
    always_comb begin
        w_opRecognized = 1'b0;
        case (sharedOperationBus)
            OP_READ, OP_WRITE, OP_RWIM, OP_INV: w_opRecognized = 1'b1;
            default:                            w_opRecognized = 1'b0;
        endcase
    end

    // Response, MESI next state and violation for the current lookup result
    always_comb begin
        w_validHit   = lookupHit && (lookupState != MESI_I);
        w_lkResp     = RESP_NOHIT;
        w_lkUpdate   = 1'b0;
        w_lkStateNew = MESI_I;
        w_lkViolate  = 1'b0;
        if (w_validHit) begin
            case (r_opcode)
                OP_READ: begin
                    w_lkStateNew = MESI_S;
                    case (lookupState)
                        MESI_M: begin
                            w_lkResp   = RESP_HITM;
                            w_lkUpdate = 1'b1;
                        end
                        MESI_E: begin
                            w_lkResp   = RESP_HIT;
                            w_lkUpdate = 1'b1;
                        end
                        default: begin
                            w_lkResp   = RESP_HIT;
                            w_lkUpdate = 1'b0;
                        end
                    endcase
                end
                OP_RWIM: begin
                    w_lkResp     = (lookupState == MESI_M) ? RESP_HITM : RESP_HIT;
                    w_lkUpdate   = 1'b1;
                    w_lkStateNew = MESI_I;
                end
                OP_INV: begin
                    // An invalidate should only ever find shared copies
                    w_lkResp     = RESP_HIT;
                    w_lkUpdate   = 1'b1;
                    w_lkStateNew = MESI_I;
                    w_lkViolate  = (lookupState != MESI_S);
                end
                OP_WRITE: begin
                    // A writeback from another cache means nobody else may hold the line
                    w_lkViolate = 1'b1;
                end
                default: begin
                    w_lkResp = RESP_NOHIT;
                end
            endcase
        end
    end

    // Protocol violations: op arriving while busy, or an illegal hit state
    assign w_errBusy   = opValid && (r_state != S_IDLE);
    assign w_errLookup = (r_state == S_LOOKUP) && lookupAck && w_lkViolate;

`ifdef SNOOP_PROTOCOL_CHECK_EN
    assign w_protocolError_nxt = w_errBusy | w_errLookup;
`else
    logic w_unused_err;
    assign w_protocolError_nxt = 1'b0;
    assign w_unused_err        = w_errBusy | w_errLookup;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_opcode_nxt     = r_opcode;
        w_index_nxt      = r_index;
        w_tag_nxt        = r_tag;
        w_way_nxt        = r_way;
        w_resp_nxt       = r_resp;
        w_update_nxt     = r_update;
        w_stateNew_nxt   = r_stateNew;
        w_lookupReq_nxt  = 1'b0;
        w_snoopValid_nxt = 1'b0;
        w_snoopBus_nxt   = RESP_NOHIT;
        w_wbReq_nxt      = 1'b0;
        w_stateWrite_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (opValid && !ownRequest && w_opRecognized) begin
                    w_state_nxt     = S_LOOKUP;
                    w_lookupReq_nxt = 1'b1;
                    w_opcode_nxt    = sharedOperationBus;
                    w_index_nxt     = snoopAddress[byteSelect+indexBits-1:byteSelect];
                    w_tag_nxt       = snoopAddress[addressSize-1 -: tagBits];
                end
            end
            S_LOOKUP: begin
                if (lookupAck) begin
                    w_state_nxt      = S_RESPOND;
                    w_way_nxt        = lookupWay;
                    w_resp_nxt       = w_lkResp;
                    w_update_nxt     = w_lkUpdate;
                    w_stateNew_nxt   = w_lkStateNew;
                    w_snoopValid_nxt = 1'b1;
                    w_snoopBus_nxt   = w_lkResp;
                end else begin
                    w_lookupReq_nxt = 1'b1;
                end
            end
            S_RESPOND: begin
                if (r_resp == RESP_HITM) begin
                    w_state_nxt = S_WRITEBACK;
                    w_wbReq_nxt = 1'b1;
                end else if (r_update) begin
                    w_state_nxt      = S_UPDATE;
                    w_stateWrite_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (wbAck) begin
                    w_state_nxt      = S_UPDATE;
                    w_stateWrite_nxt = 1'b1;
                end else begin
                    w_wbReq_nxt = 1'b1;
                end
            end
            S_UPDATE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; reset abandons any operation in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_opcode        <= 8'd0;
            r_index         <= '0;
            r_tag           <= '0;
            r_way           <= '0;
            r_resp          <= RESP_NOHIT;
            r_update        <= 1'b0;
            r_stateNew      <= MESI_I;
            r_lookupReq     <= 1'b0;
            r_snoopValid    <= 1'b0;
            r_snoopBus      <= RESP_NOHIT;
            r_wbReq         <= 1'b0;
            r_stateWrite    <= 1'b0;
            r_busy          <= 1'b0;
            r_protocolError <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_opcode        <= w_opcode_nxt;
            r_index         <= w_index_nxt;
            r_tag           <= w_tag_nxt;
            r_way           <= w_way_nxt;
            r_resp          <= w_resp_nxt;
            r_update        <= w_update_nxt;
            r_stateNew      <= w_stateNew_nxt;
            r_lookupReq     <= w_lookupReq_nxt;
            r_snoopValid    <= w_snoopValid_nxt;
            r_snoopBus      <= w_snoopBus_nxt;
            r_wbReq         <= w_wbReq_nxt;
            r_stateWrite    <= w_stateWrite_nxt;
            r_busy          <= w_busy_nxt;
            r_protocolError <= w_protocolError_nxt;
        end
    end

`ifdef SNOOP_PROTOCOL_CHECK_EN
`ifndef SYNTHESIS
    // Report each protocol violation with the offending opcode and address
    always_ff @(posedge clock) begin
        if (!reset && w_errBusy) begin
            $error("snoop protocol violation: op 0x%02h addr 0x%08h while busy",
                   sharedOperationBus, snoopAddress);
        end
        if (!reset && w_errLookup) begin
            $error("snoop protocol violation: op 0x%02h index 0x%0h tag 0x%0h state %0d",
                   r_opcode, r_index, r_tag, lookupState);
        end
    end
`endif
`endif

    // Output mapping; index and way stay stable until the next capture
    assign lookupReq     = r_lookupReq;
    assign lookupIndex   = r_index;
    assign lookupTag     = r_tag;
    assign snoopBus      = r_snoopBus;
    assign snoopValid    = r_snoopValid;
    assign wbReq         = r_wbReq;
    assign wbIndex       = r_index;
    assign wbWay         = r_way;
    assign stateWrite    = r_stateWrite;
    assign stateIndex    = r_index;
    assign stateWay      = r_way;
    assign stateNew      = r_stateNew;
    assign busy          = r_busy;
    assign protocolError = r_protocolError;

endmodule

// File: doc/l2_snoop_responder.md
# l2_snoop_responder

Snoop-side responder for the L2 cache: watches bus operations that other caches issue on the shared bus, looks the line up in the L2 tag/MESI array, and answers on `snoopBus` with NOHIT/HIT/HITM. On HITM it requests a writeback of the modified line. It then updates the line's MESI state. It sits between the shared bus and the L2 tag array. It is the responder counterpart of the L2's own bus-request path.

## Interface
- `addressSize`, 32, snooped address width
- `ways`, 8, associativity
- `indexBits`, 14, set index width
- `byteSelect`, 9, byte-offset width (512 B line)
- `tagBits`, addressSize-indexBits-byteSelect, tag width
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `opValid` in 1: one-cycle strobe; a bus op is present
- `ownRequest` in 1: op was issued by this cache (ignore it)
- `sharedOperationBus` in 8: opcode; ASCII 'R' read, 'W' write(back), 'M' RWIM, 'I' invalidate; others ignored
- `snoopAddress` in addressSize: address of the op
- `lookupReq` out 1: tag-array lookup request
- `lookupIndex` out indexBits; `lookupTag` out tagBits
- `lookupAck` in 1; `lookupHit` in 1; `lookupWay` in $clog2(ways); `lookupState` in 2 (I=00,S=01,E=10,M=11)
- `snoopBus` out 2: 00 NOHIT, 01 HIT, 10 HITM (11 never driven)
- `snoopValid` out 1: `snoopBus` is valid this cycle
- `wbReq` out 1; `wbIndex` out indexBits; `wbWay` out $clog2(ways); `wbAck` in 1
- `stateWrite` out 1; `stateIndex` out indexBits; `stateWay` out $clog2(ways); `stateNew` out 2
- `busy` out 1: high in every state except IDLE
- `protocolError` out 1: one-cycle error pulse

## Operation
- FSM states and transitions:
  - IDLE: `opValid`=1, `ownRequest`=0 and a recognized opcode captures the opcode, index and tag, then goes to LOOKUP. Anything else stays in IDLE.
  - LOOKUP: holds `lookupReq`=1 until `lookupAck`; on ack, computes the result and next MESI state, then goes to RESPOND.
  - RESPOND: drives `snoopValid`=1 for exactly one cycle. Goes to WRITEBACK if the result is HITM, else UPDATE if a state change is needed, else IDLE.
  - WRITEBACK: holds `wbReq`=1 until `wbAck`, then goes to UPDATE.
  - UPDATE: drives `stateWrite`=1 for one cycle, then goes to IDLE.
- `lookupHit`=1 with `lookupState`=I is treated as a miss.
- Response and next state per opcode:
  - 'R': M gives HITM and writeback, next S. E gives HIT, next S. S gives HIT with no update. Miss gives NOHIT.
  - 'M': M gives HITM and writeback, next I. E or S gives HIT, next I. Miss gives NOHIT.
  - 'I': S gives HIT, next I. E or M gives HIT, next I, and is a protocol violation. Miss gives NOHIT.
  - 'W': always NOHIT with no update. A valid hit is a protocol violation.
- `snoopBus`=00 whenever `snoopValid`=0.
- `opValid` while `busy`=1 is dropped (no queueing) and is a protocol violation.
- Index and tag fields: index = `snoopAddress[byteSelect+indexBits-1:byteSelect]`; tag = top `tagBits` bits.
- The way from the lookup is registered and reused for `wbWay` and `stateWay`.

## Timing
- Reset value of all outputs is 0; FSM state is IDLE. Reset mid-operation abandons the op with no `stateWrite` and no `wbReq`.
- `opValid` is sampled at edge N. `lookupReq` is high in cycle N+1.
- `lookupAck` in the same cycle as `lookupReq` gives `snoopValid` at cycle N+2 (minimum latency 2).
- `wbReq` rises the cycle after RESPOND. `stateWrite` follows `wbAck` by one cycle.
- Total occupancy for a miss is 3 cycles (LOOKUP, RESPOND, return to IDLE). A clean hit with update is 4 cycles. HITM is at least 5 cycles.
- Address and way outputs are stable from the LOOKUP/RESPOND cycle until the FSM returns to IDLE.

## Configuration
- `SNOOP_PROTOCOL_CHECK_EN` defined:
  - `protocolError` pulses one cycle on each violation: E/M on 'I', valid hit on 'W', `opValid` while busy.
  - Simulation also issues `$error` with the opcode and address.
- Not defined: `protocolError` is tied 0. Response and state behaviour is identical in both builds.

## Test plan
- 'R' to a line in M, lookup acked immediately, `wbAck` 3 cycles after `wbReq` -> `snoopBus`=10 at cycle N+2; `wbReq` held 3 cycles; `stateWrite` with `stateNew`=01.
- 'M' to a line in E -> `snoopBus`=01; no `wbReq`; `stateWrite` with `stateNew`=00; `busy` low after 4 cycles.
- 'R' to a line in S, then 'R' to a missing line -> first op gives 01 with no `stateWrite`; second gives 00. Exactly one `snoopValid` per op.
- `opValid` with `ownRequest`=1, and opcode 0x00 -> no `lookupReq`; `busy` stays 0.
- 'I' to a line in M, with the macro on -> `snoopBus`=01, `stateNew`=00, `protocolError` pulse. `opValid` during WRITEBACK -> second op dropped, `protocolError` pulse.
- `reset` asserted while in WRITEBACK -> all outputs 0 asynchronously; no `stateWrite` afterward; the next op is processed normally.
